// File: rtl/memory_stage_pkg.sv
// Shared widths, opcodes, FSM encodings and condition-code helpers for the memory stage.
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 8;
    localparam int IR_WIDTH     = 32;
    localparam int PC_WIDTH     = 32;
    localparam int REG_WIDTH    = 32;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h4A;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h4B;

    localparam logic [31:0] LED_ADDR_DEFAULT = 32'hF000_0000;

    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Condition code of a loaded word, treating it as signed.
    function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] value);
        if (value[REG_WIDTH-1])
            return CC_N;
        else if (value == '0)
            return CC_Z;
        else
            return CC_P;
    endfunction

endpackage

// File: rtl/memory_stage_mem_access_ctrl.sv
// Memory access controller: IDLE/WAIT tracking, stall generation and saturating stall counter.
module mem_access_ctrl
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        need_mem,
    input  logic        ack,
    output logic        mem_stall,
    output logic [0:0]  state,
    output logic [15:0] stall_count
);

    logic [0:0] state_next;

    assign mem_stall = need_mem && !ack;

    // WAIT is left on ack (complete) or when the request disappears (abort).
    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (need_mem && !ack) state_next = MEM_WAIT;
            MEM_WAIT: if (!need_mem || ack) state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MEM_IDLE;
            stall_count <= 16'h0000;
        end else begin
            state <= state_next;
            if (mem_stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'h0001;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: word loads/stores via req/ack, LED register decode, writeback registers.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET_N,
    input  logic                    I_LOCK,
    input  logic                    I_EX_Valid,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [IR_WIDTH-1:0]     I_IR,
    input  logic [PC_WIDTH-1:0]     I_PC,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]    I_DestValue,
    input  logic [2:0]              I_CCValue,
    input  logic [REG_WIDTH-1:0]    I_MARValue,
    input  logic [REG_WIDTH-1:0]    I_MDRValue,
    input  logic                    I_RegWEn,
    input  logic                    I_CCWEn,
    output logic                    O_DMemReq,
    output logic                    O_DMemWE,
    output logic [ADDR_W-1:0]       O_DMemAddr,
    output logic [REG_WIDTH-1:0]    O_DMemWData,
    input  logic [REG_WIDTH-1:0]    I_DMemRData,
    input  logic                    I_DMemAck,
    output logic                    O_MemStall,
    output logic                    O_LOCK,
    output logic                    O_MEM_Valid,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [IR_WIDTH-1:0]     O_IR,
    output logic [PC_WIDTH-1:0]     O_PC,
    output logic [3:0]              O_DestRegIdx,
    output logic [REG_WIDTH-1:0]    O_DestValue,
    output logic [2:0]              O_CCValue,
    output logic                    O_RegWEn,
    output logic                    O_CCWEn,
    output logic                    O_RegWEn_Signal,
    output logic                    O_CCWEn_Signal,
    output logic [REG_WIDTH-1:0]    O_LEDValue,
    output logic [15:0]             O_StallCount
);

    logic                 active;
    logic                 is_ldw;
    logic                 is_stw;
    logic                 led_hit;
    logic                 need_mem;
    logic [0:0]           mem_state;
    logic [REG_WIDTH-1:0] load_data;

    // Reset masks the lock so an in-flight request drops immediately.
    assign active   = I_LOCK && I_EX_Valid && I_RESET_N;
    assign is_ldw   = (I_Opcode == OP_LDW);
    assign is_stw   = (I_Opcode == OP_STW);
    assign led_hit  = (I_MARValue == LED_ADDR);
    assign need_mem = active && (is_ldw || is_stw) && !led_hit;

    assign O_DMemReq   = need_mem;
    assign O_DMemWE    = is_stw;
    assign O_DMemAddr  = I_MARValue[ADDR_W+1:2];
    assign O_DMemWData = I_MDRValue;

    assign O_RegWEn_Signal = I_RegWEn && I_EX_Valid && I_LOCK;
    assign O_CCWEn_Signal  = I_CCWEn && I_EX_Valid && I_LOCK;

    assign load_data = led_hit ? O_LEDValue : I_DMemRData;

    mem_access_ctrl u_ctrl (
        .clk         (I_CLOCK),
        .rst_n       (I_RESET_N),
        .need_mem    (need_mem),
        .ack         (I_DMemAck),
        .mem_stall   (O_MemStall),
        .state       (mem_state),
        .stall_count (O_StallCount)
    );

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            O_LOCK       <= 1'b0;
            O_MEM_Valid  <= 1'b0;
            O_Opcode     <= '0;
            O_IR         <= '0;
            O_PC         <= '0;
            O_DestRegIdx <= '0;
            O_DestValue  <= '0;
            O_CCValue    <= '0;
            O_RegWEn     <= 1'b0;
            O_CCWEn      <= 1'b0;
            O_LEDValue   <= '0;
        end else begin
            O_LOCK       <= I_LOCK;
            O_Opcode     <= I_Opcode;
            O_IR         <= I_IR;
            O_PC         <= I_PC;
            O_DestRegIdx <= I_DestRegIdx;
            O_DestValue  <= I_DestValue;
            O_CCValue    <= I_CCValue;
            if (!active || O_MemStall) begin
                O_MEM_Valid <= 1'b0;
                O_RegWEn    <= 1'b0;
                O_CCWEn     <= 1'b0;
            end else if (is_ldw) begin
                O_MEM_Valid <= 1'b1;
                O_DestValue <= load_data;
                O_CCValue   <= cc_of(load_data);
                O_RegWEn    <= I_RegWEn;
                O_CCWEn     <= 1'b1;
            end else if (is_stw) begin
                O_MEM_Valid <= 1'b1;
                O_RegWEn    <= 1'b0;
                O_CCWEn     <= 1'b0;
                if (led_hit)
                    O_LEDValue <= I_MDRValue;
            end else begin
                O_MEM_Valid <= 1'b1;
                O_RegWEn    <= I_RegWEn;
                O_CCWEn     <= I_CCWEn;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: passthrough, loads/stores with wait states, LED, reset and abort.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic                    I_CLOCK;
    logic                    I_RESET_N;
    logic                    I_LOCK;
    logic                    I_EX_Valid;
    logic [OPCODE_WIDTH-1:0] I_Opcode;
    logic [IR_WIDTH-1:0]     I_IR;
    logic [PC_WIDTH-1:0]     I_PC;
    logic [3:0]              I_DestRegIdx;
    logic [REG_WIDTH-1:0]    I_DestValue;
    logic [2:0]              I_CCValue;
    logic [REG_WIDTH-1:0]    I_MARValue;
    logic [REG_WIDTH-1:0]    I_MDRValue;
    logic                    I_RegWEn;
    logic                    I_CCWEn;
    logic                    O_DMemReq;
    logic                    O_DMemWE;
    logic [9:0]              O_DMemAddr;
    logic [REG_WIDTH-1:0]    O_DMemWData;
    logic [REG_WIDTH-1:0]    I_DMemRData;
    logic                    I_DMemAck;
    logic                    O_MemStall;
    logic                    O_LOCK;
    logic                    O_MEM_Valid;
    logic [OPCODE_WIDTH-1:0] O_Opcode;
    logic [IR_WIDTH-1:0]     O_IR;
    logic [PC_WIDTH-1:0]     O_PC;
    logic [3:0]              O_DestRegIdx;
    logic [REG_WIDTH-1:0]    O_DestValue;
    logic [2:0]              O_CCValue;
    logic                    O_RegWEn;
    logic                    O_CCWEn;
    logic                    O_RegWEn_Signal;
    logic                    O_CCWEn_Signal;
    logic [REG_WIDTH-1:0]    O_LEDValue;
    logic [15:0]             O_StallCount;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    memory_stage #(.ADDR_W(10), .LED_ADDR(32'hF000_0000)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
        .I_EX_Valid(I_EX_Valid), .I_Opcode(I_Opcode), .I_IR(I_IR), .I_PC(I_PC),
        .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue), .I_CCValue(I_CCValue),
        .I_MARValue(I_MARValue), .I_MDRValue(I_MDRValue), .I_RegWEn(I_RegWEn),
        .I_CCWEn(I_CCWEn), .O_DMemReq(O_DMemReq), .O_DMemWE(O_DMemWE),
        .O_DMemAddr(O_DMemAddr), .O_DMemWData(O_DMemWData), .I_DMemRData(I_DMemRData),
        .I_DMemAck(I_DMemAck), .O_MemStall(O_MemStall), .O_LOCK(O_LOCK),
        .O_MEM_Valid(O_MEM_Valid), .O_Opcode(O_Opcode), .O_IR(O_IR), .O_PC(O_PC),
        .O_DestRegIdx(O_DestRegIdx), .O_DestValue(O_DestValue), .O_CCValue(O_CCValue),
        .O_RegWEn(O_RegWEn), .O_CCWEn(O_CCWEn), .O_RegWEn_Signal(O_RegWEn_Signal),
        .O_CCWEn_Signal(O_CCWEn_Signal), .O_LEDValue(O_LEDValue), .O_StallCount(O_StallCount)
    );

    // Clock and reset: flops update on the falling edge; inputs change just after the rising edge.
    initial I_CLOCK = 1'b1;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] mar, input logic [31:0] mdr,
                         input logic [31:0] dest, input logic regwen, input logic valid,
                         input logic lock);
        I_Opcode    = op;
        I_MARValue  = mar;
        I_MDRValue  = mdr;
        I_DestValue = dest;
        I_RegWEn    = regwen;
        I_CCWEn     = 1'b1;
        I_EX_Valid  = valid;
        I_LOCK      = lock;
    endtask

    task automatic next_cycle();
        @(negedge I_CLOCK);
        #1;
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic after_fall();
        @(negedge I_CLOCK);
        #1;
    endtask

    initial begin
        I_RESET_N    = 1'b0;
        I_IR         = 32'h1234_5678;
        I_PC         = 32'h0000_0100;
        I_DestRegIdx = 4'd3;
        I_CCValue    = 3'b010;
        I_DMemRData  = '0;
        I_DMemAck    = 1'b0;
        drive(OP_ADD, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_valid", {31'b0, O_MEM_Valid}, 0);
        check("rst_dest", O_DestValue, 0);
        check("rst_stallcnt", {16'b0, O_StallCount}, 0);
        check("rst_led", O_LEDValue, 0);
        @(posedge I_CLOCK);
        #1;
        I_RESET_N = 1'b1;

        // ADD passthrough
        drive(OP_ADD, 32'h0, 32'h0, 32'd5, 1'b1, 1'b1, 1'b1);
        #1;
        check("add_req", {31'b0, O_DMemReq}, 0);
        check("add_regwen_sig", {31'b0, O_RegWEn_Signal}, 1);
        after_fall();
        check("add_dest", O_DestValue, 5);
        check("add_valid", {31'b0, O_MEM_Valid}, 1);
        check("add_regwen", {31'b0, O_RegWEn}, 1);
        check("add_pc", O_PC, 32'h0000_0100);
        check("add_lock", {31'b0, O_LOCK}, 1);
        @(posedge I_CLOCK);
        #1;

        // LDW acked in the same cycle, negative value
        drive(OP_LDW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        I_DMemRData = 32'hFFFF_FFF0;
        I_DMemAck   = 1'b1;
        exp_q.push_back(32'hFFFF_FFF0);
        #1;
        check("ldw_req", {31'b0, O_DMemReq}, 1);
        check("ldw_we", {31'b0, O_DMemWE}, 0);
        check("ldw_addr", {22'b0, O_DMemAddr}, 4);
        check("ldw_stall", {31'b0, O_MemStall}, 0);
        after_fall();
        check("ldw_dest", O_DestValue, exp_q.pop_front());
        check("ldw_cc", {29'b0, O_CCValue}, {29'b0, CC_N});
        check("ldw_ccwen", {31'b0, O_CCWEn}, 1);
        check("ldw_valid", {31'b0, O_MEM_Valid}, 1);
        @(posedge I_CLOCK);
        #1;

        // STW with three wait cycles
        drive(OP_STW, 32'h20, 32'd7, 32'h0, 1'b1, 1'b1, 1'b1);
        I_DMemAck = 1'b0;
        #1;
        check("stw_req", {31'b0, O_DMemReq}, 1);
        check("stw_we", {31'b0, O_DMemWE}, 1);
        check("stw_wdata", O_DMemWData, 7);
        check("stw_addr", {22'b0, O_DMemAddr}, 8);
        for (int i = 0; i < 3; i++) begin
            check("stw_stall", {31'b0, O_MemStall}, 1);
            after_fall();
            check("stw_bubble_valid", {31'b0, O_MEM_Valid}, 0);
            check("stw_bubble_regwen", {31'b0, O_RegWEn}, 0);
            @(posedge I_CLOCK);
            #1;
        end
        I_DMemAck = 1'b1;
        #1;
        check("stw_ack_stall", {31'b0, O_MemStall}, 0);
        after_fall();
        check("stw_valid", {31'b0, O_MEM_Valid}, 1);
        check("stw_regwen", {31'b0, O_RegWEn}, 0);
        check("stw_ccwen", {31'b0, O_CCWEn}, 0);
        check("stw_stallcnt", {16'b0, O_StallCount}, 3);
        @(posedge I_CLOCK);
        #1;

        // STW then LDW on the LED register
        I_DMemAck = 1'b0;
        drive(OP_STW, 32'hF000_0000, 32'hA5, 32'h0, 1'b1, 1'b1, 1'b1);
        #1;
        check("led_st_req", {31'b0, O_DMemReq}, 0);
        check("led_st_stall", {31'b0, O_MemStall}, 0);
        after_fall();
        check("led_value", O_LEDValue, 32'hA5);
        check("led_st_regwen", {31'b0, O_RegWEn}, 0);
        @(posedge I_CLOCK);
        #1;
        drive(OP_LDW, 32'hF000_0000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(32'hA5);
        #1;
        check("led_ld_req", {31'b0, O_DMemReq}, 0);
        after_fall();
        check("led_ld_dest", O_DestValue, exp_q.pop_front());
        check("led_ld_cc", {29'b0, O_CCValue}, {29'b0, CC_P});
        check("led_ld_regwen", {31'b0, O_RegWEn}, 1);
        @(posedge I_CLOCK);
        #1;

        // Reset pulsed while waiting on memory
        drive(OP_STW, 32'h30, 32'h9, 32'h0, 1'b1, 1'b1, 1'b1);
        after_fall();
        check("rstw_cnt_before", {16'b0, O_StallCount}, 4);
        @(posedge I_CLOCK);
        #1;
        I_RESET_N = 1'b0;
        #1;
        check("rstw_req", {31'b0, O_DMemReq}, 0);
        check("rstw_stall", {31'b0, O_MemStall}, 0);
        check("rstw_cnt", {16'b0, O_StallCount}, 0);
        check("rstw_led", O_LEDValue, 0);
        check("rstw_lock", {31'b0, O_LOCK}, 0);
        I_DMemAck = 1'b1;
        after_fall();
        check("rstw_ack_valid", {31'b0, O_MEM_Valid}, 0);
        @(posedge I_CLOCK);
        #1;
        I_LOCK    = 1'b0;
        I_RESET_N = 1'b1;
        #1;
        check("rstw_late_req", {31'b0, O_DMemReq}, 0);
        after_fall();
        check("rstw_late_valid", {31'b0, O_MEM_Valid}, 0);
        check("rstw_late_cnt", {16'b0, O_StallCount}, 0);
        @(posedge I_CLOCK);
        #1;

        // Invalid LDW
        I_DMemAck = 1'b0;
        drive(OP_LDW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        #1;
        check("inv_req", {31'b0, O_DMemReq}, 0);
        check("inv_regwen_sig", {31'b0, O_RegWEn_Signal}, 0);
        after_fall();
        check("inv_valid", {31'b0, O_MEM_Valid}, 0);
        check("inv_regwen", {31'b0, O_RegWEn}, 0);
        @(posedge I_CLOCK);
        #1;

        // Ack arriving together with lock falling: abort wins
        drive(OP_LDW, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        I_DMemRData = 32'h0000_0011;
        after_fall();
        check("abort_bubble", {31'b0, O_MEM_Valid}, 0);
        @(posedge I_CLOCK);
        #1;
        I_LOCK    = 1'b0;
        I_DMemAck = 1'b1;
        #1;
        check("abort_req", {31'b0, O_DMemReq}, 0);
        check("abort_stall", {31'b0, O_MemStall}, 0);
        after_fall();
        check("abort_valid", {31'b0, O_MEM_Valid}, 0);
        check("abort_regwen", {31'b0, O_RegWEn}, 0);
        check("abort_olock", {31'b0, O_LOCK}, 0);
        check("abort_cnt", {16'b0, O_StallCount}, 1);
        @(posedge I_CLOCK);
        #1;

        // Stall counter saturation
        I_DMemAck = 1'b0;
        drive(OP_LDW, 32'h50, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        repeat (65540) @(negedge I_CLOCK);
        #1;
        check("sat_cnt", {16'b0, O_StallCount}, 32'h0000_FFFF);
        @(posedge I_CLOCK);
        #1;
        I_DMemAck   = 1'b1;
        I_DMemRData = 32'h0;
        exp_q.push_back(32'h0);
        after_fall();
        check("sat_cnt_hold", {16'b0, O_StallCount}, 32'h0000_FFFF);
        check("sat_ld_dest", O_DestValue, exp_q.pop_front());
        check("sat_ld_cc", {29'b0, O_CCValue}, {29'b0, CC_Z});
        check("q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
